switch_debounce_conditioner: RTL and testbench
==============================================

// Module: switch_debounce_conditioner
// PURPOSE
//  Upstream conditioning stage for the RGB LED PWM driver. It takes the 16 raw slide switches
//  (an RGB565 word: [15:11] R, [10:5] G/B field, [4:0] field), synchronises and debounces each
//  bit, and presents a glitch-free registered word. A one-cycle change strobe and a per-bit
//  change mask mark every update of that word.
// PARAMETERS
//  WIDTH            16    number of switch bits conditioned
//  SYNC_STAGES      2     flops in each bit's synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  1000  consecutive cycles a new level must persist before it is accepted (>=1)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  sw_raw       in   WIDTH  asynchronous raw switch levels
//  hold         in   1      1 = freeze sw_stable; debounce counters keep running
//  sw_stable    out  WIDTH  debounced switch word, feeds the LED block's switch-panel input
//  sw_changed   out  1      1-cycle pulse: sw_stable updated on this edge
//  change_mask  out  WIDTH  bits of sw_stable that toggled on this edge; 0 when sw_changed=0
// BEHAVIOUR
//  - Interface: one clock (clk); reset (rst) is synchronous and active-high.
//  - Reset: sync chains, sw_stable, counters, sw_changed and change_mask all 0. This has
//    priority over every other condition. A bounce in progress is discarded.
//  - Synchroniser: sw_raw[i] goes through SYNC_STAGES flops; the last stage is sync[i].
//  - Per bit i, on each edge, with counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
//      * sync[i]==sw_stable[i]           -> cnt<=0
//      * differ, cnt<DEBOUNCE_CYCLES-1   -> cnt<=cnt+1
//      * differ, cnt==DEBOUNCE_CYCLES-1  -> accept: cnt<=0, and sw_stable[i]<=sync[i] if hold=0
//  - Latency: a clean step on sw_raw sampled at edge 1 appears on sw_stable at edge
//    SYNC_STAGES+DEBOUNCE_CYCLES. There is no early or late update.
//  - Glitch rejection: a level that differs for fewer than DEBOUNCE_CYCLES consecutive sync
//    cycles never reaches sw_stable. Its counter returns to 0 on the first matching cycle.
//  - hold=1 at the accept point: the acceptance is dropped (cnt<=0, sw_stable unchanged).
//    If the difference persists, the bit re-qualifies a full DEBOUNCE_CYCLES after hold
//    falls. hold has no effect on the sync chain.
//  - Multiple bits may accept on the same edge: a single sw_changed pulse, and change_mask
//    carries all of them.
//  - sw_changed and change_mask are registered and coincide with the sw_stable update edge.
//    change_mask == old sw_stable ^ new sw_stable.
//  - DEBOUNCE_CYCLES=1: accept on the first differing sync cycle (pure synchroniser plus
//    registered output).
//  - Counters never exceed DEBOUNCE_CYCLES-1 and never wrap.
// STRUCTURE
//  - Shared package led_pkg:
//      * localparam SW_WIDTH=16
//      * RGB565 field slice constants R_MSB=15, R_LSB=11, G_MSB=10, G_LSB=5, B_MSB=4, B_LSB=0
//        (shared with the PWM LED stage)
//  - One sub-module, debounce_bit (sync chain + counter + accept logic for one bit), is
//    instantiated WIDTH times via generate.
//  - The top level holds only the hold gating and the change-strobe/mask register.
// TESTING (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1. Step, no bounce: rst, then sw_raw 0x0000->0xF800 at edge 1 -> sw_stable=0xF800 exactly
//     at edge 6; sw_changed=1 and change_mask=0xF800 for that one cycle only.
//  2. Glitch: bit 0 high for 3 cycles, then low -> sw_stable stays 0x0000, sw_changed never
//     asserts. Bit 0 high for 4 cycles -> accepted at edge 6.
//  3. Bounce: bit 5 toggles 1,0,1,1,1,1 -> accepted 4 edges after the last toggle plus
//     sync delay; exactly one sw_changed pulse.
//  4. Simultaneous: sw_raw 0x0000->0x07E0 in one cycle -> one pulse, change_mask=0x07E0.
//     Then 0x07E0->0x001F -> change_mask=0x07FF.
//  5. Hold: hold=1 while 0xFFFF is applied -> sw_stable stays 0x0000. Drop hold ->
//     0xFFFF appears no earlier than 4 edges later.
//  6. Reset mid-bounce: rst for 1 cycle while cnt=2 -> all outputs 0 on the next edge.
//     A fresh full 6-edge latency is required afterwards.

Source files
------------

// File: rtl/led_pkg.sv
// Constants shared by the switch conditioner and the PWM LED stage.
// Includes the RGB565 field slices and the debounce counter sizing.
package led_pkg;

    localparam int SW_WIDTH = 16;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Counter width able to hold 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_conditioner_debounce_bit.sv
// One switch bit: synchroniser chain, persistence counter and stable register.
// accept_o flags the qualifying edge whether or not the update is enabled.
module debounce_bit
    import led_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic upd_en_i,
    output logic stable_o,
    output logic accept_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign stable_o = stable_q;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept_o = 1'b0;
        if (sync_bit == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            // A held-off acceptance still restarts the count from zero.
            accept_o = 1'b1;
            cnt_d    = '0;
            if (upd_en_i) stable_d = sync_bit;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/switch_debounce_conditioner.sv
// Debounces the raw switch word bit by bit and registers a change strobe
// plus the mask of bits that toggled on each stable-word update.
module switch_debounce_conditioner
    import led_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] sw_stable_o,
    output logic             sw_changed_o,
    output logic [WIDTH-1:0] change_mask_o
);

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] mask_d, mask_q;
    logic             changed_d, changed_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .raw_i   (sw_raw_i[gi]),
            .upd_en_i(~hold_i),
            .stable_o(sw_stable_o[gi]),
            .accept_o(accept[gi])
        );
    end

    // An accepted bit always differs from the stable word, so the mask is old ^ new.
    assign mask_d    = hold_i ? '0 : accept;
    assign changed_d = |mask_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            changed_q <= changed_d;
        end
    end

    assign change_mask_o = mask_q;
    assign sw_changed_o  = changed_q;

endmodule

// File: tb/tb_switch_debounce_conditioner.sv
// Scenario bench for the switch conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Expected stable-word updates are queued at stimulus time and matched on each strobe.
module tb_switch_debounce_conditioner;

    localparam int W   = 16;
    localparam int DC  = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + DC;   // edges from drive to update, counted from the drive negedge

    typedef struct {
        int          cyc;
        logic [W-1:0] stable;
        logic [W-1:0] mask;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic         hold = 1'b0;
    logic [W-1:0] sw_stable;
    logic         sw_changed;
    logic [W-1:0] change_mask;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    switch_debounce_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_raw_i     (sw_raw),
        .hold_i       (hold),
        .sw_stable_o  (sw_stable),
        .sw_changed_o (sw_changed),
        .change_mask_o(change_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: every strobe must match the oldest queued update.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sw_changed === 1'b1) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse cyc=%0d stable=%h mask=%h", cyc, sw_stable, change_mask);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    vectors++;
                    if (cyc !== e.cyc) begin
                        miscompares++;
                        $display("FAIL pulse_edge got=%0d exp=%0d", cyc, e.cyc);
                    end
                    vectors++;
                    if (sw_stable !== e.stable) begin
                        miscompares++;
                        $display("FAIL pulse_stable got=%h exp=%h", sw_stable, e.stable);
                    end
                    vectors++;
                    if (change_mask !== e.mask) begin
                        miscompares++;
                        $display("FAIL pulse_mask got=%h exp=%h", change_mask, e.mask);
                    end
                end
            end else if (change_mask !== '0 || sw_changed !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_strobe cyc=%0d changed=%b mask=%h", cyc, sw_changed, change_mask);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_update(input logic [W-1:0] stable, input logic [W-1:0] mask);
        exp_t e;
        e.cyc    = cyc + LAT;
        e.stable = stable;
        e.mask   = mask;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            step(1);
            n++;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout pending=%0d exp=0", name, q.size());
            q.delete();
        end
        step(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        hold = 1'b0;
        sw_raw = '0;
        step(1);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic check_stable(input string name, input logic [W-1:0] exp);
        vectors++;
        if (sw_stable !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, sw_stable, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        check_stable("reset_stable", '0);
        vectors++;
        if (sw_changed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_changed got=%b exp=0", sw_changed);
        end
        vectors++;
        if (change_mask !== '0) begin
            miscompares++;
            $display("FAIL reset_mask got=%h exp=0000", change_mask);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        step(2);
    endtask

    task automatic test_step();
        do_reset();
        sw_raw = 16'hF800;
        expect_update(16'hF800, 16'hF800);
        drain("step");
        check_stable("step_stable", 16'hF800);
    endtask

    task automatic test_glitch();
        do_reset();
        sw_raw = 16'h0001;
        step(3);
        sw_raw = 16'h0000;
        step(8);
        check_stable("glitch_rejected", 16'h0000);
        sw_raw = 16'h0001;
        expect_update(16'h0001, 16'h0001);
        step(4);
        sw_raw = 16'h0000;
        expect_update(16'h0000, 16'h0001);
        drain("glitch");
        check_stable("glitch_return", 16'h0000);
    endtask

    task automatic test_bounce();
        do_reset();
        sw_raw = 16'h0020;
        step(1);
        sw_raw = 16'h0000;
        step(1);
        sw_raw = 16'h0020;
        expect_update(16'h0020, 16'h0020);
        drain("bounce");
        check_stable("bounce_stable", 16'h0020);
    endtask

    task automatic test_simultaneous();
        do_reset();
        sw_raw = 16'h07E0;
        expect_update(16'h07E0, 16'h07E0);
        drain("simul_a");
        check_stable("simul_a_stable", 16'h07E0);
        sw_raw = 16'h001F;
        expect_update(16'h001F, 16'h07FF);
        drain("simul_b");
        check_stable("simul_b_stable", 16'h001F);
    endtask

    task automatic test_hold();
        do_reset();
        hold = 1'b1;
        sw_raw = 16'hFFFF;
        // Accept points fall at drive+6 and drive+10; hold covers both.
        step(LAT + DC);
        check_stable("hold_frozen", 16'h0000);
        hold = 1'b0;
        begin
            exp_t e;
            e.cyc    = cyc + DC;
            e.stable = 16'hFFFF;
            e.mask   = 16'hFFFF;
            q.push_back(e);
        end
        drain("hold");
        check_stable("hold_release", 16'hFFFF);
    endtask

    task automatic test_reset_mid();
        do_reset();
        sw_raw = 16'h0100;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_stable("rstmid_stable", 16'h0000);
        vectors++;
        if (sw_changed !== 1'b0 || change_mask !== '0) begin
            miscompares++;
            $display("FAIL rstmid_strobe got=%b/%h exp=0/0000", sw_changed, change_mask);
        end
        expect_update(16'h0100, 16'h0100);
        drain("rstmid");
        check_stable("rstmid_final", 16'h0100);
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_hold();
        test_reset_mid();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
